// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_sequencer
// Description : Per-sample control sequencer for the FIR datapath. Accepts a
//               sample, writes it into a circular delay line (dm2), runs a
//               TAPS-cycle MAC loop over the coefficients (dm1) and the delay
//               line, drains the ALU pipeline and presents the result with a
//               ready/valid handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : TAPS (power of two, 2..256), COEF_BASE, DLINE_BASE,
//               MAC_LAT (1..7)
// Ports       : clk, reset (async, active-low)
//               sample_valid/sample_ready  - input sample handshake
//               result_valid/result_ready  - result handshake
//               busy                       - any state other than IDLE
//               pc                         - datapath instruction address
//               dm1_a/dm2_a, dm1_we/dm2_we - data memory address / write
//               loop_we                    - load loop register (TAPS-1)
//               dag1/2_re, dag1/2_we       - address generator strobes
//               rf1_we1                    - capture accumulator
//               alu1_ctrl                  - 000 NOP, 001 CLR, 010 MAC
// Option      : FIR_SEQ_STATUS_EN adds output sample_cnt[15:0], a count of
//               completed result handshakes.
// ============================================================================
module fir_sequencer #(
    parameter int          TAPS       = 16,
    parameter logic [15:0] COEF_BASE  = 16'h0000,
    parameter logic [15:0] DLINE_BASE = 16'h0100,
    parameter int          MAC_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic [15:0] pc,
    output logic [15:0] dm1_a,
    output logic [15:0] dm2_a,
    output logic        dm1_we,
    output logic        dm2_we,
    output logic        loop_we,
    output logic        dag1_re,
    output logic        dag2_re,
    output logic        dag1_we,
    output logic        dag2_we,
    output logic        rf1_we1,
    output logic [2:0]  alu1_ctrl
`ifdef FIR_SEQ_STATUS_EN
    ,
    output logic [15:0] sample_cnt
`endif
);

    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    // The tap counter doubles as the drain counter, so it must also hold MAC_LAT-1.
    localparam int KW = (AW > 3) ? AW : 3;

    localparam logic [KW-1:0] c_LAST_TAP   = KW'(TAPS - 1);
    localparam logic [KW-1:0] c_LAST_DRAIN = KW'(MAC_LAT - 1);

    localparam logic [2:0] c_ALU_NOP = 3'b000;
    localparam logic [2:0] c_ALU_CLR = 3'b001;
    localparam logic [2:0] c_ALU_MAC = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   w_head_nxt;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_nxt;
    logic [15:0]     r_pc;
    logic [15:0]     w_pc_nxt;
    logic [15:0]     r_dm1_a;
    logic [15:0]     r_dm2_a;
    logic [15:0]     w_dm1_a;
    logic [15:0]     w_dm2_a;
    logic [AW-1:0]   w_tap_off;
    logic            w_dm2_we;
    logic            w_loop_we;
    logic            w_dag_re;
    logic            w_dag2_we;
    logic            w_rf1_we1;
    logic [2:0]      w_alu;
    logic            w_out_hs;

    // Newest sample sits at head; tap k reads head-k, wrapping in AW bits.
    assign w_tap_off = r_head - r_k[AW-1:0];
    assign w_out_hs  = (r_state == S_OUT) && result_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_k_nxt     = r_k;
        w_pc_nxt    = r_pc;
        w_dm1_a     = r_dm1_a;
        w_dm2_a     = r_dm2_a;
        w_dm2_we    = 1'b0;
        w_loop_we   = 1'b0;
        w_dag_re    = 1'b0;
        w_dag2_we   = 1'b0;
        w_rf1_we1   = 1'b0;
        w_alu       = c_ALU_NOP;

        case (r_state)
            S_IDLE: begin
                w_pc_nxt = 16'd0;
                if (sample_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_dm2_a     = DLINE_BASE + {{(16-AW){1'b0}}, r_head};
                w_dm2_we    = 1'b1;
                w_dag2_we   = 1'b1;
                w_loop_we   = 1'b1;
                w_alu       = c_ALU_CLR;
                w_k_nxt     = '0;
                w_pc_nxt    = r_pc + 16'd1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                w_dm1_a  = COEF_BASE + {{(16-AW){1'b0}}, r_k[AW-1:0]};
                w_dm2_a  = DLINE_BASE + {{(16-AW){1'b0}}, w_tap_off};
                w_dag_re = 1'b1;
                w_alu    = c_ALU_MAC;
                w_pc_nxt = r_pc + 16'd1;
                if (r_k == c_LAST_TAP) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_DRAIN: begin
                w_pc_nxt = r_pc + 16'd1;
                if (r_k == c_LAST_DRAIN) begin
                    w_rf1_we1   = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_OUT: begin
                if (result_ready) begin
                    w_head_nxt  = r_head + 1'b1;
                    w_pc_nxt    = 16'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_pc_nxt    = 16'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_k     <= '0;
            r_pc    <= 16'd0;
            r_dm1_a <= 16'd0;
            r_dm2_a <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_k     <= w_k_nxt;
            r_pc    <= w_pc_nxt;
            // Address holds: outputs keep their last driven value.
            r_dm1_a <= w_dm1_a;
            r_dm2_a <= w_dm2_a;
        end
    end

`ifdef FIR_SEQ_STATUS_EN
    logic [15:0] r_sample_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_cnt <= 16'd0;
        end else if (w_out_hs) begin
            r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

    assign sample_ready = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_OUT);
    assign pc           = r_pc;
    assign dm1_a        = w_dm1_a;
    assign dm2_a        = w_dm2_a;
    assign dm1_we       = 1'b0;
    assign dm2_we       = w_dm2_we;
    assign loop_we      = w_loop_we;
    assign dag1_re      = w_dag_re;
    assign dag2_re      = w_dag_re;
    assign dag1_we      = 1'b0;
    assign dag2_we      = w_dag2_we;
    assign rf1_we1      = w_rf1_we1;
    assign alu1_ctrl    = w_alu;

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sequencer
// Description : Directed self-checking bench for fir_sequencer with default
//               parameters (TAPS=16, MAC_LAT=2, DLINE_BASE=16'h0100).
//               The sample_cnt scenario is built only with FIR_SEQ_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;

    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic        result_ready = 1'b0;
    logic        sample_ready, result_valid, busy;
    logic [15:0] pc, dm1_a, dm2_a;
    logic        dm1_we, dm2_we, loop_we, dag1_re, dag2_re, dag1_we, dag2_we, rf1_we1;
    logic [2:0]  alu1_ctrl;
`ifdef FIR_SEQ_STATUS_EN
    logic [15:0] sample_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Observations recorded by run_one
    logic [15:0] obs_load_a;
    logic [15:0] obs_mac_a [NT];
    logic        obs_rv;

    fir_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .pc           (pc),
        .dm1_a        (dm1_a),
        .dm2_a        (dm2_a),
        .dm1_we       (dm1_we),
        .dm2_we       (dm2_we),
        .loop_we      (loop_we),
        .dag1_re      (dag1_re),
        .dag2_re      (dag2_re),
        .dag1_we      (dag1_we),
        .dag2_we      (dag2_we),
        .rf1_we1      (rf1_we1),
        .alu1_ctrl    (alu1_ctrl)
`ifdef FIR_SEQ_STATUS_EN
        ,
        .sample_cnt   (sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    // One full sample with result_ready=1 (21 cycles), recording addresses.
    task automatic run_one();
        result_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        obs_load_a   = dm2_a;
        sample_valid = 1'b0;
        for (int k = 0; k < NT; k++) begin
            tick();
            obs_mac_a[k] = dm2_a;
        end
        tick();
        tick();
        tick();
        obs_rv = result_valid;
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] strobes;
        do_reset();
        strobes = {dm1_we, dm2_we, loop_we, dag1_re, dag2_re, dag1_we, dag2_we, rf1_we1, result_valid, busy};
        n_checks++;
        if (sample_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_sample_ready got=%b exp=1", sample_ready);
        end
        n_checks++;
        if (strobes !== 10'd0) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=0", strobes);
        end
        n_checks++;
        if ({pc, dm1_a, dm2_a} !== 48'd0 || alu1_ctrl !== 3'b000) begin
            n_fail++; $display("FAIL reset_regs got pc=%h a1=%h a2=%h alu=%b exp=0", pc, dm1_a, dm2_a, alu1_ctrl);
        end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n_checks++;
        if (dm2_we !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_then_load got we=%b busy=%b exp=1,1", dm2_we, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        result_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n_checks++;
        if (dm2_we !== 1'b1 || dm2_a !== 16'h0100 || loop_we !== 1'b1 || dag2_we !== 1'b1
            || alu1_ctrl !== 3'b001 || pc !== 16'd0) begin
            n_fail++; $display("FAIL load_cycle got we=%b a2=%h lw=%b d2w=%b alu=%b pc=%0d exp 1,0100,1,1,001,0",
                               dm2_we, dm2_a, loop_we, dag2_we, alu1_ctrl, pc);
        end
        for (int k = 0; k < NT; k++) begin
            logic [15:0] exp_a2;
            tick();
            exp_a2 = 16'h0100 + 16'((0 - k) & 15);
            n_checks++;
            if (dm1_a !== 16'(k) || dm2_a !== exp_a2 || dag1_re !== 1'b1 || dag2_re !== 1'b1
                || alu1_ctrl !== 3'b010 || pc !== 16'(k + 1) || dm2_we !== 1'b0) begin
                n_fail++; $display("FAIL mac_k%0d got a1=%h a2=%h re=%b%b alu=%b pc=%0d exp a1=%h a2=%h pc=%0d",
                                   k, dm1_a, dm2_a, dag1_re, dag2_re, alu1_ctrl, pc, 16'(k), exp_a2, k + 1);
            end
        end
        tick();
        n_checks++;
        if (alu1_ctrl !== 3'b000 || rf1_we1 !== 1'b0 || pc !== 16'd17 || dag1_re !== 1'b0 || dm1_a !== 16'd15) begin
            n_fail++; $display("FAIL drain1 got alu=%b rf=%b pc=%0d re=%b a1=%h exp 000,0,17,0,000f",
                               alu1_ctrl, rf1_we1, pc, dag1_re, dm1_a);
        end
        tick();
        n_checks++;
        if (rf1_we1 !== 1'b1 || pc !== 16'd18 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain2 got rf=%b pc=%0d rv=%b exp 1,18,0", rf1_we1, pc, result_valid);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || pc !== 16'd19 || busy !== 1'b1 || rf1_we1 !== 1'b0) begin
            n_fail++; $display("FAIL out_cycle got rv=%b pc=%0d busy=%b rf=%b exp 1,19,1,0", result_valid, pc, busy, rf1_we1);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || sample_ready !== 1'b1 || pc !== 16'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL after_out got rv=%b rdy=%b pc=%0d busy=%b exp 0,1,0,0", result_valid, sample_ready, pc, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 0; s < NT + 1; s++) begin
            run_one();
            n_checks++;
            if (obs_load_a !== 16'h0100 + 16'(s % NT)) begin
                n_fail++; $display("FAIL wrap_load_s%0d got=%h exp=%h", s, obs_load_a, 16'h0100 + 16'(s % NT));
            end
            n_checks++;
            if (obs_rv !== 1'b1) begin
                n_fail++; $display("FAIL wrap_rv_s%0d got=%b exp=1", s, obs_rv);
            end
            if (s == 1) begin
                for (int k = 0; k < NT; k++) begin
                    logic [15:0] exp_a2;
                    exp_a2 = 16'h0100 + 16'((1 - k) & 15);
                    n_checks++;
                    if (obs_mac_a[k] !== exp_a2) begin
                        n_fail++; $display("FAIL wrap_mac_k%0d got=%h exp=%h", k, obs_mac_a[k], exp_a2);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        result_ready = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (19) tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (result_valid !== 1'b1 || pc !== 16'd19 || sample_ready !== 1'b0 || dm2_a !== 16'h0101) begin
                n_fail++; $display("FAIL bp_hold_c%0d got rv=%b pc=%0d rdy=%b a2=%h exp 1,19,0,0101",
                                   c, result_valid, pc, sample_ready, dm2_a);
            end
            sample_valid = 1'b1;
            tick();
        end
        // Still in OUT here; handshake together with a new sample.
        result_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0 || pc !== 16'd0) begin
            n_fail++; $display("FAIL b2b_idle got rv=%b rdy=%b busy=%b pc=%0d exp 0,1,0,0", result_valid, sample_ready, busy, pc);
        end
        tick();
        sample_valid = 1'b0;
        n_checks++;
        if (dm2_we !== 1'b1 || dm2_a !== 16'h0101) begin
            n_fail++; $display("FAIL b2b_load got we=%b a2=%h exp 1,0101", dm2_we, dm2_a);
        end
        repeat (20) tick();
    endtask

    task automatic test_reset_mid_mac();
        do_reset();
        run_one();
        result_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (dm1_a !== 16'd7 || dag1_re !== 1'b1) begin
            n_fail++; $display("FAIL mid_mac_pre got a1=%h re=%b exp 0007,1", dm1_a, dag1_re);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (sample_ready !== 1'b1 || busy !== 1'b0 || dag1_re !== 1'b0 || dag2_re !== 1'b0 || pc !== 16'd0
            || alu1_ctrl !== 3'b000 || dm2_we !== 1'b0 || dm1_a !== 16'd0) begin
            n_fail++; $display("FAIL mid_mac_reset got rdy=%b busy=%b re=%b%b pc=%0d alu=%b we=%b a1=%h exp 1,0,00,0,000,0,0",
                               sample_ready, busy, dag1_re, dag2_re, pc, alu1_ctrl, dm2_we, dm1_a);
        end
        tick();
        reset = 1'b1;
        run_one();
        n_checks++;
        if (obs_load_a !== 16'h0100) begin
            n_fail++; $display("FAIL mid_mac_head got=%h exp=0100", obs_load_a);
        end
    endtask

`ifdef FIR_SEQ_STATUS_EN
    task automatic test_status();
        do_reset();
        n_checks++;
        if (sample_cnt !== 16'd0) begin
            n_fail++; $display("FAIL cnt_reset got=%0d exp=0", sample_cnt);
        end
        repeat (3) run_one();
        n_checks++;
        if (sample_cnt !== 16'd3) begin
            n_fail++; $display("FAIL cnt_three got=%0d exp=3", sample_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_reset_mid_mac();
`ifdef FIR_SEQ_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
